// File: rtl/inta_sequencer_pkg.sv
// Shared definitions for the interrupt-acknowledge sequencer.
package inta_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACK1 = 3'd1,
    GAP  = 3'd2,
    ACK2 = 3'd3,
    HOLD = 3'd4,
    EOI  = 3'd5
  } seq_state_t;

  // Non-specific EOI command word (OCW2)
  localparam logic [7:0] OCW2_NS_EOI = 8'h20;

  // PIC strobes are active-low
  localparam logic INTA_ACTIVE = 1'b0;
  localparam logic WR_ACTIVE   = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// Core / PIC facing signals of the interrupt-acknowledge sequencer.
interface inta_sequencer_if;
  logic       INT;
  logic       int_enable;
  logic [7:0] data_in;
  logic       vec_ack;
  logic       eoi_req;
  logic       INTA;
  logic       WR;
  logic       A0;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] vector;
  logic       vec_valid;
  logic       busy;

  // sequencer side
  modport master (
    input  INT, int_enable, data_in, vec_ack, eoi_req,
    output INTA, WR, A0, data_out, data_oe, vector, vec_valid, busy
  );

  // core / PIC side
  modport slave (
    output INT, int_enable, data_in, vec_ack, eoi_req,
    input  INTA, WR, A0, data_out, data_oe, vector, vec_valid, busy
  );
endinterface

// File: rtl/inta_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous INT pin.
module inta_sequencer_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // shift the raw input through two flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/inta_sequencer.sv
// CPU-side 8259 INTA two-pulse sequencer with non-specific EOI write.
module inta_sequencer
  import inta_sequencer_pkg::*;
#(
  parameter int PULSE_CYCLES = 3,
  parameter int GAP_CYCLES   = 2,
  parameter int WR_CYCLES    = 2
) (
  input  logic             clk,
  input  logic             reset,
  inta_sequencer_if.master bus
);
  localparam int CW = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, WR_CYCLES + 2)) + 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
  // EOI counts down WR_CYCLES+1 .. 0; WR is low for counts WR_CYCLES .. 1
  localparam logic [CW-1:0] EOI_LD   = CW'(WR_CYCLES + 1);
  localparam logic [CW-1:0] WR_HI    = CW'(WR_CYCLES);

  seq_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          int_s;
  logic          eoi_pend;
  logic          eoi_go, int_go, capture;
  logic          inta_q, wr_q, oe_q, vv_q;
  logic [7:0]    dout_q, vec_q;

  inta_sequencer_sync2 u_sync (.clk(clk), .rst(reset), .d(bus.INT), .q(int_s));

  assign eoi_go  = (state == IDLE) && (bus.eoi_req || eoi_pend);
  assign int_go  = int_s && bus.int_enable && !vv_q;
  assign capture = (state == ACK2) && (cnt == '0);

  // next state and counter; the counter reloads on every state entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (eoi_go) begin
          state_nx = EOI;
          cnt_nx   = EOI_LD;
        end else if (int_go) begin
          state_nx = ACK1;
          cnt_nx   = PULSE_LD;
        end
      end
      ACK1: begin
        if (cnt == '0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LD;
        end else cnt_nx = cnt - ONE;
      end
      GAP: begin
        // INT is not re-examined here: once started, the pair always completes
        if (cnt == '0) begin
          state_nx = ACK2;
          cnt_nx   = PULSE_LD;
        end else cnt_nx = cnt - ONE;
      end
      ACK2: begin
        if (cnt == '0) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end else cnt_nx = cnt - ONE;
      end
      HOLD: state_nx = IDLE;
      EOI: begin
        if (cnt == '0) state_nx = IDLE;
        else cnt_nx = cnt - ONE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // strobes are registered from the next state so they change only on clock edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inta_q <= ~INTA_ACTIVE;
      wr_q   <= ~WR_ACTIVE;
      oe_q   <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      inta_q <= (state_nx == ACK1 || state_nx == ACK2) ? INTA_ACTIVE : ~INTA_ACTIVE;
      wr_q   <= (state_nx == EOI && cnt_nx >= ONE && cnt_nx <= WR_HI) ? WR_ACTIVE : ~WR_ACTIVE;
      oe_q   <= (state_nx == EOI);
      dout_q <= (state_nx == EOI) ? OCW2_NS_EOI : 8'h00;
    end
  end

  // vector capture on the last ACK2 cycle; a coincident vec_ack loses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_q <= 8'h00;
      vv_q  <= 1'b0;
    end else if (capture) begin
      vec_q <= bus.data_in;
      vv_q  <= 1'b1;
    end else if (bus.vec_ack) begin
      vv_q  <= 1'b0;
    end
  end

  // one-deep EOI request latch; repeats while pending merge into one
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 eoi_pend <= 1'b0;
    else if (eoi_go)           eoi_pend <= 1'b0;
    else if (bus.eoi_req)      eoi_pend <= 1'b1;
  end

  assign bus.INTA      = inta_q;
  assign bus.WR        = wr_q;
  assign bus.A0        = 1'b0;
  assign bus.data_out  = dout_q;
  assign bus.data_oe   = oe_q;
  assign bus.vector    = vec_q;
  assign bus.vec_valid = vv_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: stimulus pushes expected acks/EOIs,
// a negedge monitor measures the pin protocol and pops on each delivery.
module tb_inta_sequencer;
  localparam int PULSE = 3;
  localparam int GAPC  = 2;
  localparam int WRC   = 2;

  typedef struct {
    bit         is_eoi;
    logic [7:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inta_sequencer_if bif();

  inta_sequencer #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAPC), .WR_CYCLES(WRC)) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bif.master)
  );

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         ovl     = 0;
  logic [7:0] cur_vec = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ack(input logic [7:0] v);
    exp_t e;
    e.is_eoi = 1'b0;
    e.vec    = v;
    exp_q.push_back(e);
  endtask

  task automatic push_eoi();
    exp_t e;
    e.is_eoi = 1'b1;
    e.vec    = 8'h20;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor / data_in driver ----------------
  logic p_inta, p_oe, p_vv;
  int   falls, low_run, high_run, oe_run, wr_low, wr_first, eoi_bad;

  initial begin : monitor
    exp_t e;
    p_inta = 1'b1; p_oe = 1'b0; p_vv = 1'b0;
    falls = 0; low_run = 0; high_run = 0;
    oe_run = 0; wr_low = 0; wr_first = 0; eoi_bad = 0;
    bif.data_in = 8'hFF;
    forever begin
      @(negedge clk);
      if (rst) begin
        falls = 0; low_run = 0; high_run = 0;
        oe_run = 0; wr_low = 0; wr_first = 0; eoi_bad = 0;
        p_inta = 1'b1; p_oe = 1'b0; p_vv = 1'b0;
        bif.data_in = ~cur_vec;
      end else begin
        if (bif.INTA === 1'b0 && bif.WR === 1'b0) ovl++;
        if (bif.A0 !== 1'b0) eoi_bad++;
        // INTA pulse and gap widths
        if (bif.INTA === 1'b0) begin
          if (p_inta) begin
            falls++;
            if (falls == 2) chk("gap_len", high_run, GAPC);
            low_run = 0;
          end
          low_run++;
        end else begin
          if (!p_inta) begin
            chk("pulse_len", low_run, PULSE);
            high_run = 0;
          end
          high_run++;
        end
        // the correct vector is on the bus only for the last low cycle of pulse 2
        bif.data_in = (bif.INTA === 1'b0 && falls == 2 && low_run == PULSE) ? cur_vec : ~cur_vec;
        // vector delivery
        if (bif.vec_valid && !p_vv) begin
          chk("ack_pulses", falls, 2);
          falls = 0;
          if (exp_q.size() == 0) chk("unexpected_vec", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("vec_kind_is_eoi", e.is_eoi, 0);
            chk("vector", bif.vector, e.vec);
          end
        end
        // EOI write window
        if (bif.data_oe) begin
          oe_run++;
          if (bif.data_out !== 8'h20) eoi_bad++;
          if (bif.WR === 1'b0) begin
            wr_low++;
            if (wr_first == 0) wr_first = oe_run;
          end
        end else if (bif.WR !== 1'b1) eoi_bad++;
        if (!bif.data_oe && p_oe) begin
          if (exp_q.size() == 0) chk("unexpected_eoi", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("eoi_kind_is_eoi", e.is_eoi, 1);
          end
          chk("eoi_oe_len", oe_run, WRC + 2);
          chk("eoi_wr_len", wr_low, WRC);
          chk("eoi_wr_setup", wr_first, 2);
          chk("eoi_bus", eoi_bad, 0);
          oe_run = 0; wr_low = 0; wr_first = 0; eoi_bad = 0;
        end
        p_inta = bif.INTA;
        p_oe   = bif.data_oe;
        p_vv   = bif.vec_valid;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_inta(input logic lvl, input string name);
    int k = 0;
    while (bif.INTA !== lvl && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(name, k < 60, 1);
  endtask

  task automatic wait_vv();
    int k = 0;
    while (bif.vec_valid !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("vv_timeout", k < 60, 1);
  endtask

  task automatic take_vector();
    wait_vv();
    repeat (2) @(negedge clk);
    bif.vec_ack = 1'b1;
    @(negedge clk);
    bif.vec_ack = 1'b0;
    chk("vv_clear", bif.vec_valid, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bif.busy !== 1'b0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", k < 60, 1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int bad;
    rst            = 1'b1;
    bif.INT        = 1'b0;
    bif.int_enable = 1'b0;
    bif.vec_ack    = 1'b0;
    bif.eoi_req    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {bif.INTA, bif.WR, bif.A0, bif.data_oe, bif.vec_valid, bif.busy, bif.data_out, bif.vector},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    rst = 1'b0;
    bif.int_enable = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic acknowledge, 3 clk from raw INT to first INTA fall
    cur_vec = 8'h4B;
    push_ack(8'h4B);
    bif.INT = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_before", bif.INTA, 1);
    @(negedge clk);
    chk("lat_first_fall", bif.INTA, 0);
    bif.INT = 1'b0;
    take_vector();
    wait_idle();

    // 2: interrupts masked, then enable starts within one clock
    bif.int_enable = 1'b0;
    bif.INT = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bif.INTA !== 1'b1 || bif.busy !== 1'b0) bad++;
    end
    chk("masked_idle", bad, 0);
    cur_vec = 8'hA5;
    push_ack(8'hA5);
    bif.int_enable = 1'b1;
    @(negedge clk);
    chk("enable_start", bif.INTA, 0);
    bif.INT = 1'b0;
    take_vector();
    wait_idle();

    // 3: INT drops during the gap, sequence still completes
    cur_vec = 8'h3C;
    push_ack(8'h3C);
    bif.INT = 1'b1;
    wait_inta(1'b0, "t3_fall");
    wait_inta(1'b1, "t3_gap");
    bif.INT = 1'b0;
    take_vector();
    wait_idle();

    // 4: EOI requested twice during the ack -> one EOI after it
    cur_vec = 8'hC3;
    push_ack(8'hC3);
    bif.INT = 1'b1;
    wait_inta(1'b0, "t4_fall");
    bif.INT = 1'b0;
    push_eoi();
    bif.eoi_req = 1'b1;
    @(negedge clk);
    bif.eoi_req = 1'b0;
    @(negedge clk);
    bif.eoi_req = 1'b1;
    @(negedge clk);
    bif.eoi_req = 1'b0;
    take_vector();
    wait_idle();

    // 5: reset in the middle of ACK2, then a fresh sequence
    cur_vec = 8'h99;
    push_ack(8'h99);
    bif.INT = 1'b1;
    wait_inta(1'b0, "t5_fall1");
    wait_inta(1'b1, "t5_gap");
    wait_inta(1'b0, "t5_fall2");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_inta_async", bif.INTA, 1);
    chk("rst_vv", bif.vec_valid, 0);
    chk("rst_busy", bif.busy, 0);
    exp_q.delete();
    @(negedge clk);
    cur_vec = 8'h5A;
    push_ack(8'h5A);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_lat_before", bif.INTA, 1);
    @(negedge clk);
    chk("t5_fresh_ack1", bif.INTA, 0);
    bif.INT = 1'b0;
    take_vector();
    wait_idle();

    // 6a: held INT with an unconsumed vector does not retrigger
    cur_vec = 8'h66;
    push_ack(8'h66);
    bif.INT = 1'b1;
    wait_inta(1'b0, "t6_fall");
    wait_vv();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bif.INTA !== 1'b1 || bif.busy !== 1'b0) bad++;
    end
    chk("t6_hold_off", bad, 0);
    bif.int_enable = 1'b0;
    bif.vec_ack = 1'b1;
    @(negedge clk);
    bif.vec_ack = 1'b0;
    chk("t6_vv_clear", bif.vec_valid, 0);
    @(negedge clk);
    // 6b: eoi_req and an enabled interrupt in the same IDLE clock -> EOI first
    push_eoi();
    cur_vec = 8'h11;
    push_ack(8'h11);
    bif.int_enable = 1'b1;
    bif.eoi_req = 1'b1;
    @(negedge clk);
    bif.eoi_req = 1'b0;
    chk("t6_eoi_first", {bif.data_oe, bif.INTA}, {1'b1, 1'b1});
    wait_inta(1'b0, "t6b_fall");
    bif.INT = 1'b0;
    take_vector();
    wait_idle();

    // random acks with optional EOI requests at random offsets
    for (int it = 0; it < 25; it++) begin
      logic [7:0] v;
      int j, d, ad, fell, vvs;
      v    = 8'($urandom);
      j    = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 14));
      d    = $urandom_range(0, 5);
      ad   = $urandom_range(2, 5);
      fell = -1;
      vvs  = -1;
      cur_vec = v;
      // ack starts on the 3rd edge after INT rises; an EOI seen on or before it goes first
      if (j != 0 && j <= 3) push_eoi();
      push_ack(v);
      if (j > 3) push_eoi();
      bif.INT = 1'b1;
      for (int c = 0; c < 60; c++) begin
        bif.eoi_req = (j != 0 && c == j - 1);
        if (fell < 0 && bif.INTA === 1'b0) fell = c;
        if (fell >= 0 && c == fell + d) bif.INT = 1'b0;
        if (vvs < 0 && bif.vec_valid === 1'b1) vvs = c;
        bif.vec_ack = (vvs >= 0 && c == vvs + ad);
        if (vvs >= 0 && c == vvs + ad + 1) chk("rnd_vv_clear", bif.vec_valid, 0);
        @(negedge clk);
      end
      bif.eoi_req = 1'b0;
      bif.vec_ack = 1'b0;
      bif.INT     = 1'b0;
      chk("rnd_ack_done", vvs >= 0, 1);
      wait_idle();
    end

    chk("no_inta_wr_overlap", ovl, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
